uart_rx_mod: RTL and testbench
==============================

Name: uart_rx_mod

Overview:
- UART receiver that decodes the serial frames produced by the team's UART transmitter.
- Frame format: 1 start bit (0), DATA_BITS data bits LSB-first, 1 even-parity bit, 1 stop bit (1); each bit lasts CLOCK_DIV clk cycles.
- Sits between the external RX pin and the SoC-side consumer (register block or RX FIFO). Delivers one byte per frame with a 1-cycle valid pulse, plus parity and framing status.

Parameters:
- CLOCK_DIV, 54: clk cycles per bit (921600 baud at 50 MHz). Must be >= 8.
- DATA_BITS, 8: number of data bits per frame.

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous, active-high reset.
- uartRx  input  1  serial line, asynchronous to clk, idles high.
- dataRx  output  DATA_BITS  last received data word.
- rxValid  output  1  one-cycle pulse; a frame has completed.
- parityErr  output  1  even-parity check failed for the last frame.
- frameErr  output  1  stop bit sampled as 0 for the last frame.
- uartBusyRx  output  1  high whenever the FSM is not in IDLE.

Behaviour:
- Reset (asynchronous, active-high): state=IDLE; synchroniser flops=1; dataRx=0; rxValid=0; parityErr=0; frameErr=0; counters=0. Reset mid-frame abandons the frame immediately, and no rxValid is produced.
- Synchroniser: uartRx passes through 2 flops (rxSync). rxPrev holds the previous rxSync value. All decisions use rxSync only.
- Counter widths: clk_count is $clog2(CLOCK_DIV) bits; bit_index is $clog2(DATA_BITS+2) bits. HALF=CLOCK_DIV/2 (integer division).
- IDLE: on a falling edge (rxPrev=1, rxSync=0), set clk_count=0 and go to START. A line held low (break) does not retrigger until it has returned high.
- START: increment clk_count until clk_count==HALF-1, then sample.
  - Sample=1: glitch. Return to IDLE with no outputs changed.
  - Sample=0: clk_count=0, bit_index=0, go to DATA.
- DATA: count to CLOCK_DIV-1, then sample into shift[bit_index], clk_count=0, bit_index+1.
  - After DATA_BITS+1 samples (data + parity), go to STOP.
- STOP: count to CLOCK_DIV-1, then sample the stop bit. In that same cycle:
  - dataRx <= shift[DATA_BITS-1:0].
  - parityErr <= XOR of all DATA_BITS+1 sampled bits (0 = good, even parity).
  - frameErr <= ~stopSample.
  - rxValid <= 1 for exactly one cycle.
  - state <= IDLE.
- rxValid is asserted even when an error flag is set. dataRx, parityErr and frameErr hold until the next frame completes.
- Latency: rxValid rises 2 + HALF + (DATA_BITS+2)*CLOCK_DIV (+/-1) cycles after the uartRx falling edge.
- Back-to-back frames: IDLE is re-entered mid-stop-bit, so a start edge arriving at any time from half a bit after the stop-bit centre is accepted.
- No flow control and no overrun detection. The consumer must take dataRx on rxValid.

Optional Feature:
- Macro: UART_RX_MAJORITY_EN.
- Defined: each bit (start, data, parity, stop) is sampled at 3 consecutive counts, centre-1, centre and centre+1. The bit value is the majority of the 3 samples. The decision is taken at centre+1, and the following bit's count is shortened by 1 cycle so the bit period stays at CLOCK_DIV.
- Not defined: a single sample is taken at the centre count, with no majority logic synthesised.

Test Plan:
- Send a valid frame 0xA5 (parity 0, stop 1) at CLOCK_DIV=54 -> rxValid is a single 1-cycle pulse, dataRx=0xA5, parityErr=0, frameErr=0, uartBusyRx low afterwards.
- Send 0x01 with the parity bit forced to 0 -> dataRx=0x01, parityErr=1, frameErr=0.
- Send 0x3C with the stop bit forced to 0, then hold the line low for 3 bit times -> frameErr=1 and exactly one rxValid. No new frame starts until the line has returned high and fallen again.
- Drive a 10-cycle low glitch on an idle line -> FSM returns to IDLE, no rxValid, outputs unchanged.
- Send 0x00 then 0xFF back-to-back with a minimal stop bit -> two rxValid pulses, dataRx=0x00 then 0xFF, both with no errors.
- Assert rst during data bit 4 of a frame -> all outputs are 0 immediately and no rxValid appears. The next clean frame 0x5A is received correctly.
  - With UART_RX_MAJORITY_EN defined, additionally inject a 1-cycle inverted glitch at the centre of each data bit of 0x5A -> dataRx=0x5A.

Source files
------------

// File: rtl/uart_rx_mod.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx_mod
// Brief    : UART receiver. Frame = start(0), DATA_BITS data LSB-first,
//            even parity, stop(1); CLOCK_DIV clk cycles per bit. Delivers
//            one word per frame with a one-cycle rxValid pulse plus parity
//            and framing status.
// Options  : UART_RX_MAJORITY_EN - when defined, every bit is decided by a
//            2-of-3 vote over the samples at centre-1, centre and centre+1.
//            When undefined, a single centre sample is used.
// Revision : 1.0 - initial release
// ============================================================================
module uart_rx_mod #(
    parameter int CLOCK_DIV = 54,
    parameter int DATA_BITS = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 uartRx,
    output logic [DATA_BITS-1:0] dataRx,
    output logic                 rxValid,
    output logic                 parityErr,
    output logic                 frameErr,
    output logic                 uartBusyRx
);

    localparam int CNT_W = $clog2(CLOCK_DIV);
    localparam int IDX_W = $clog2(DATA_BITS + 2);
    localparam int HALF  = CLOCK_DIV / 2;

    // The vote decides one count after the centre, so the start-bit decision
    // moves one count later. For data/parity/stop the counter restarts at the
    // decision point (centre+1), which shortens the following count by one and
    // keeps the decision at CLOCK_DIV-1.
`ifdef UART_RX_MAJORITY_EN
    localparam logic [CNT_W-1:0] START_DECIDE = CNT_W'(HALF);
`else
    localparam logic [CNT_W-1:0] START_DECIDE = CNT_W'(HALF - 1);
`endif
    localparam logic [CNT_W-1:0] BIT_DECIDE = CNT_W'(CLOCK_DIV - 1);
    localparam logic [IDX_W-1:0] LAST_INDEX = IDX_W'(DATA_BITS);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t             state;
    logic               rx_meta;
    logic               rx_sync;
    logic               rx_prev;
    logic [CNT_W-1:0]   clk_count;
    logic [IDX_W-1:0]   bit_index;
    logic [DATA_BITS:0] shift;       // data bits plus parity, LSB-first
    logic [CNT_W-1:0]   decide_count;
    logic               decide;
    logic               bit_value;

    // Two-flop synchroniser plus edge-history flop; the line idles high
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_meta <= uartRx;
            rx_sync <= rx_meta;
            rx_prev <= rx_sync;
        end
    end

    // Count at which the current bit's value is taken
    always_comb begin
        decide_count = BIT_DECIDE;
        if (state == START) begin
            decide_count = START_DECIDE;
        end
    end

    assign decide = (state != IDLE) && (clk_count == decide_count);

`ifdef UART_RX_MAJORITY_EN
    logic [1:0] votes;

    // Capture the two early samples (centre-1 and centre) of the current bit
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            votes <= 2'b11;
        end else if (state != IDLE) begin
            if (clk_count == decide_count - CNT_W'(2)) begin
                votes[0] <= rx_sync;
            end
            if (clk_count == decide_count - CNT_W'(1)) begin
                votes[1] <= rx_sync;
            end
        end
    end

    // Third sample is the live value at centre+1; take the 2-of-3 majority
    assign bit_value = (votes[0] & votes[1]) |
                       (votes[0] & rx_sync)  |
                       (votes[1] & rx_sync);
`else
    assign bit_value = rx_sync;
`endif

    // Frame FSM: start-edge detect, start validation, data/parity shift,
    // stop check and registered result/status outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            clk_count  <= '0;
            bit_index  <= '0;
            shift      <= '0;
            dataRx     <= '0;
            rxValid    <= 1'b0;
            parityErr  <= 1'b0;
            frameErr   <= 1'b0;
            uartBusyRx <= 1'b0;
        end else begin
            rxValid <= 1'b0;
            case (state)
                IDLE: begin
                    // Needs a genuine high-to-low transition, so a held-low
                    // line cannot retrigger
                    if (rx_prev && !rx_sync) begin
                        clk_count  <= '0;
                        state      <= START;
                        uartBusyRx <= 1'b1;
                    end
                end

                START: begin
                    if (decide) begin
                        if (bit_value) begin
                            // Line back high at mid-start: treat as a glitch
                            state      <= IDLE;
                            uartBusyRx <= 1'b0;
                        end else begin
                            clk_count <= '0;
                            bit_index <= '0;
                            state     <= DATA;
                        end
                    end else begin
                        clk_count <= clk_count + CNT_W'(1);
                    end
                end

                DATA: begin
                    if (decide) begin
                        shift     <= {bit_value, shift[DATA_BITS:1]};
                        clk_count <= '0;
                        bit_index <= bit_index + IDX_W'(1);
                        // Last of the data+parity samples just taken
                        if (bit_index == LAST_INDEX) begin
                            state <= STOP;
                        end
                    end else begin
                        clk_count <= clk_count + CNT_W'(1);
                    end
                end

                STOP: begin
                    if (decide) begin
                        // Return to IDLE mid-stop-bit so a following start
                        // edge is not missed
                        dataRx     <= shift[DATA_BITS-1:0];
                        parityErr  <= ^shift;
                        frameErr   <= ~bit_value;
                        rxValid    <= 1'b1;
                        clk_count  <= '0;
                        state      <= IDLE;
                        uartBusyRx <= 1'b0;
                    end else begin
                        clk_count <= clk_count + CNT_W'(1);
                    end
                end

                default: begin
                    state      <= IDLE;
                    uartBusyRx <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_mod.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_rx_mod
// Brief    : Self-checking bench for uart_rx_mod: vector table, hand-written
//            corner sequences and random frames against a frame-level model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_rx_mod;

    localparam int CLOCK_DIV = 54;
    localparam int DATA_BITS = 8;
    localparam int HALF      = CLOCK_DIV / 2;

    logic       clk;
    logic       rst;
    logic       uartRx;
    logic [7:0] dataRx;
    logic       rxValid;
    logic       parityErr;
    logic       frameErr;
    logic       uartBusyRx;

    uart_rx_mod #(
        .CLOCK_DIV(CLOCK_DIV),
        .DATA_BITS(DATA_BITS)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .uartRx    (uartRx),
        .dataRx    (dataRx),
        .rxValid   (rxValid),
        .parityErr (parityErr),
        .frameErr  (frameErr),
        .uartBusyRx(uartBusyRx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [7:0] data;
        logic       perr;
        logic       ferr;
    } obs_t;

    obs_t got_q[$];

    typedef struct {
        logic [7:0] data;
        logic       par;
        logic       stop;
        logic [7:0] exp_data;
        logic       exp_perr;
        logic       exp_ferr;
    } vec_t;

    vec_t vecs[9];

    // Record every cycle rxValid is seen high; a stretched pulse shows up as
    // extra entries
    always @(negedge clk) begin
        if (rxValid) begin
            got_q.push_back({dataRx, parityErr, frameErr});
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [10:0] make_frame(input logic [7:0] d, input logic par, input logic stop);
        return {stop, par, d, 1'b0};
    endfunction

    // Drive the first nslots bit slots of a frame; optional one-cycle
    // inversion at the centre of every data bit
    task automatic drive_bits(input logic [10:0] bits, input int nslots, input bit glitch);
        for (int s = 0; s < nslots; s++) begin
            for (int c = 0; c < CLOCK_DIV; c++) begin
                uartRx = (glitch && s >= 1 && s <= 8 && c == HALF) ? ~bits[s] : bits[s];
                @(negedge clk);
            end
        end
    endtask

    task automatic idle(input int n);
        uartRx = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    task automatic expect_frame(input string name, input logic [7:0] d, input logic pe, input logic fe);
        obs_t o;
        int   waited;
        waited = 0;
        while (got_q.size() == 0 && waited < 2 * CLOCK_DIV) begin
            @(negedge clk);
            waited++;
        end
        if (got_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s: got no rxValid, expected data 0x%0h", name, d);
        end else begin
            o = got_q.pop_front();
            check($sformatf("%s.data", name), o.data, d);
            check($sformatf("%s.perr", name), o.perr, pe);
            check($sformatf("%s.ferr", name), o.ferr, fe);
        end
    endtask

    initial begin
        logic [7:0] rd;
        logic       rpar;
        logic       rstop;

        vecs[0] = '{8'hA5, 1'b0, 1'b1, 8'hA5, 1'b0, 1'b0};
        vecs[1] = '{8'h01, 1'b0, 1'b1, 8'h01, 1'b1, 1'b0};
        vecs[2] = '{8'h01, 1'b1, 1'b1, 8'h01, 1'b0, 1'b0};
        vecs[3] = '{8'h3C, 1'b0, 1'b0, 8'h3C, 1'b0, 1'b1};
        vecs[4] = '{8'h00, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0};
        vecs[5] = '{8'hFF, 1'b0, 1'b1, 8'hFF, 1'b0, 1'b0};
        vecs[6] = '{8'hFF, 1'b1, 1'b1, 8'hFF, 1'b1, 1'b0};
        vecs[7] = '{8'h80, 1'b0, 1'b0, 8'h80, 1'b1, 1'b1};
        vecs[8] = '{8'h5A, 1'b1, 1'b1, 8'h5A, 1'b1, 1'b0};

        // Reset state
        uartRx = 1'b1;
        rst    = 1'b1;
        repeat (3) @(negedge clk);
        check("reset.dataRx", dataRx, 8'h00);
        check("reset.rxValid", rxValid, 1'b0);
        check("reset.parityErr", parityErr, 1'b0);
        check("reset.frameErr", frameErr, 1'b0);
        check("reset.busy", uartBusyRx, 1'b0);
        rst = 1'b0;
        idle(2 * CLOCK_DIV);

        // Clean 0xA5: single pulse, idle afterwards
        drive_bits(make_frame(8'hA5, 1'b0, 1'b1), 11, 1'b0);
        expect_frame("a5", 8'hA5, 1'b0, 1'b0);
        idle(4);
        check("a5.single_pulse", got_q.size(), 0);
        check("a5.busy_after", uartBusyRx, 1'b0);

        // Vector table
        for (int i = 0; i < 9; i++) begin
            idle(CLOCK_DIV);
            drive_bits(make_frame(vecs[i].data, vecs[i].par, vecs[i].stop), 11, 1'b0);
            expect_frame($sformatf("vec%0d", i), vecs[i].exp_data, vecs[i].exp_perr, vecs[i].exp_ferr);
        end

        // Back-to-back 0x00 then 0xFF with a one-bit stop
        idle(CLOCK_DIV);
        drive_bits(make_frame(8'h00, 1'b0, 1'b1), 11, 1'b0);
        drive_bits(make_frame(8'hFF, 1'b0, 1'b1), 11, 1'b0);
        expect_frame("b2b0", 8'h00, 1'b0, 1'b0);
        expect_frame("b2b1", 8'hFF, 1'b0, 1'b0);

        // 0x3C with stop forced low, then a held-low break
        idle(CLOCK_DIV);
        drive_bits(make_frame(8'h3C, 1'b0, 1'b0), 11, 1'b0);
        uartRx = 1'b0;
        repeat (3 * CLOCK_DIV) @(negedge clk);
        expect_frame("break", 8'h3C, 1'b0, 1'b1);
        check("break.single_pulse", got_q.size(), 0);
        check("break.busy_low", uartBusyRx, 1'b0);
        idle(2 * CLOCK_DIV);
        check("break.no_retrigger", got_q.size(), 0);

        // 10-cycle low glitch on an idle line
        uartRx = 1'b0;
        repeat (5) @(negedge clk);
        check("glitch.busy_seen", uartBusyRx, 1'b1);
        repeat (5) @(negedge clk);
        idle(2 * CLOCK_DIV);
        check("glitch.busy_after", uartBusyRx, 1'b0);
        check("glitch.no_valid", got_q.size(), 0);
        check("glitch.dataRx_held", dataRx, 8'h3C);
        check("glitch.perr_held", parityErr, 1'b0);
        check("glitch.ferr_held", frameErr, 1'b1);

        // Reset during data bit 4 of 0xC3
        drive_bits(make_frame(8'hC3, 1'b0, 1'b1), 5, 1'b0);
        uartRx = 1'b0;
        repeat (HALF) @(negedge clk);
        rst = 1'b1;
        #1;
        check("midrst.dataRx", dataRx, 8'h00);
        check("midrst.ferr", frameErr, 1'b0);
        check("midrst.perr", parityErr, 1'b0);
        check("midrst.rxValid", rxValid, 1'b0);
        check("midrst.busy", uartBusyRx, 1'b0);
        uartRx = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        idle(12 * CLOCK_DIV);
        check("midrst.no_valid", got_q.size(), 0);
`ifdef UART_RX_MAJORITY_EN
        drive_bits(make_frame(8'h5A, 1'b0, 1'b1), 11, 1'b1);
`else
        drive_bits(make_frame(8'h5A, 1'b0, 1'b1), 11, 1'b0);
`endif
        expect_frame("after_rst", 8'h5A, 1'b0, 1'b0);

        // Random frames against the frame-level model
        for (int i = 0; i < 16; i++) begin
            rd    = 8'($urandom);
            rpar  = 1'($urandom_range(0, 1));
            rstop = ($urandom_range(0, 3) != 0);
            idle($urandom_range(3, CLOCK_DIV));
            drive_bits(make_frame(rd, rpar, rstop), 11, 1'b0);
            expect_frame($sformatf("rnd%0d", i), rd, ^{rd, rpar}, ~rstop);
        end

        idle(2 * CLOCK_DIV);
        check("final.no_extra_valid", got_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
